// File: rtl/libucode.sv
// Shared microcode definitions: micro-PC width, entry points, indirection
// field positions, ROM word layout and the sequencer state enum.
package libucode;

   localparam int NUPCMSB = 4;
   localparam int UPCW    = NUPCMSB + 1;

   // Microcode entry points
   localparam logic [NUPCMSB:0] UPC_TRAP  = 5'd0;
   localparam logic [NUPCMSB:0] UPC_STD   = 5'd7;
   localparam logic [NUPCMSB:0] UPC_FLUSH = 5'd13;
   localparam logic [NUPCMSB:0] UPC_LAST  = 5'd31;

   // Register-field LSB positions inside a 32-bit instruction
   localparam int UCIPOS_RD  = 25;
   localparam int UCIPOS_RS1 = 14;
   localparam int UCIPOS_RS2 = 0;

   // A field with this bit set takes its value from the macro instruction
   localparam logic [4:0] UCI_MASK = 5'b10000;

   typedef struct packed {
      logic [31:0] inst;
      logic        cwp_rs1;
      logic        cwp_rd;
      logic        uend;
   } microcode_out_type;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ucode_seq_state_type;

   // Build one ROM word: {op=2, rd, op3, rs1, i, simm13/rs2} plus flags
   function automatic microcode_out_type mk_uc(
      input logic [5:0]  op3,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic        i,
      input logic [12:0] lo,
      input logic        cwp_rs1,
      input logic        cwp_rd,
      input logic        uend
   );
      microcode_out_type w;
      w.inst    = {2'b10, rd, op3, rs1, i, lo};
      w.cwp_rs1 = cwp_rs1;
      w.cwp_rd  = cwp_rd;
      w.uend    = uend;
      return w;
   endfunction

endpackage

// File: rtl/ucode_rom.sv
// 32-entry microcode ROM, combinational read.
// Fields with the top bit set (0x10..0x1f) are indirect references to the
// macro instruction; small values are scratch register indices.
module ucode_rom
   import libucode::*;
(
   input  logic [NUPCMSB:0]  addr,
   output microcode_out_type data
);

   // Constant table lookup; unused slots hold a terminating no-op
   always_comb begin
      data = mk_uc(6'h00, 5'h00, 5'h00, 1'b1, 13'h0000, 1'b0, 1'b0, 1'b1);
      case (addr)
         // TRAP: 4-entry sequence
         UPC_TRAP: data = mk_uc(6'h02, 5'h10, 5'h11, 1'b0, 13'h0001, 1'b1, 1'b1, 1'b0);
         5'd1:     data = mk_uc(6'h00, 5'h02, 5'h10, 1'b1, 13'h0004, 1'b1, 1'b0, 1'b0);
         5'd2:     data = mk_uc(6'h04, 5'h10, 5'h02, 1'b0, 13'h0012, 1'b0, 1'b1, 1'b0);
         5'd3:     data = mk_uc(6'h38, 5'h00, 5'h03, 1'b1, 13'h0000, 1'b0, 1'b0, 1'b1);
         // Single entry: indirect rd, scratch rs1, immediate form
         5'd4:     data = mk_uc(6'h02, 5'h10, 5'h05, 1'b1, 13'h0015, 1'b0, 1'b1, 1'b1);
         // STD: 2-entry sequence
         UPC_STD:  data = mk_uc(6'h24, 5'h10, 5'h11, 1'b0, 13'h0010, 1'b1, 1'b0, 1'b0);
         5'd8:     data = mk_uc(6'h24, 5'h11, 5'h12, 1'b1, 13'h0004, 1'b1, 1'b0, 1'b1);
         // FLUSH: single entry
         UPC_FLUSH: data = mk_uc(6'h3a, 5'h00, 5'h00, 1'b1, 13'h0000, 1'b0, 1'b0, 1'b1);
         // Last slot has no terminator; the sequencer forces retirement
         UPC_LAST: data = mk_uc(6'h00, 5'h01, 5'h02, 1'b0, 13'h0003, 1'b0, 1'b0, 1'b0);
         default:  ;
      endcase
   end

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer: walks the ROM from a start address, one entry per
// accepted output beat, substituting macro-instruction register fields.
module ucode_seq
   import libucode::*;
#(
   parameter int TIDW = 6
) (
   input  logic              gclk,
   input  logic              rst,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [NUPCMSB:0]  start_upc,
   input  logic [TIDW-1:0]   start_tid,
   input  logic [31:0]       start_inst,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic              out_cwp_rs1,
   output logic              out_cwp_rd,
   output logic              out_last,
   output logic [NUPCMSB:0]  out_upc,
   output logic [TIDW-1:0]   out_tid,
   output logic              seq_err
);

   ucode_seq_state_type state;
   logic [31:0]         inst_q;
   logic                wrap_q;     // current beat was forced last at address 31

   logic                beat_acc;
   logic                start_acc;
   logic                load;
   logic [NUPCMSB:0]    rom_addr;
   microcode_out_type   rom_w;
   logic [31:0]         src_inst;
   logic [31:0]         exp_inst;
   logic                wrap_nxt;
   logic                last_nxt;

   assign beat_acc    = out_valid & out_ready;
   assign start_ready = !rst & !flush & ((state == IDLE) | (beat_acc & out_last));
   assign start_acc   = start_valid & start_ready;
   assign load        = start_acc | ((state == RUN) & beat_acc & !out_last);

   // A new start reads its entry and indirects against the incoming
   // instruction directly, so there is no bubble between sequences.
   assign rom_addr = start_acc ? start_upc : out_upc + UPCW'(1);
   assign src_inst = start_acc ? start_inst : inst_q;

   ucode_rom u_rom (
      .addr (rom_addr),
      .data (rom_w)
   );

   // Register-field indirection; rs2 only in register form (i bit clear)
   always_comb begin
      exp_inst = rom_w.inst;
      if ((rom_w.inst[UCIPOS_RD +: 5] & UCI_MASK) != 5'd0)
         exp_inst[UCIPOS_RD +: 5] = src_inst[UCIPOS_RD +: 5];
      if ((rom_w.inst[UCIPOS_RS1 +: 5] & UCI_MASK) != 5'd0)
         exp_inst[UCIPOS_RS1 +: 5] = src_inst[UCIPOS_RS1 +: 5];
      if (!rom_w.inst[13] && ((rom_w.inst[UCIPOS_RS2 +: 5] & UCI_MASK) != 5'd0))
         exp_inst[UCIPOS_RS2 +: 5] = src_inst[UCIPOS_RS2 +: 5];
   end

   // Running off the end of the ROM terminates the sequence
   assign wrap_nxt = (rom_addr == UPC_LAST) & !rom_w.uend;
   assign last_nxt = rom_w.uend | wrap_nxt;

   // Sequencer FSM with registered outputs; flush overrides everything
   always_ff @(posedge gclk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         inst_q      <= '0;
         wrap_q      <= 1'b0;
         out_valid   <= 1'b0;
         out_inst    <= '0;
         out_cwp_rs1 <= 1'b0;
         out_cwp_rd  <= 1'b0;
         out_last    <= 1'b0;
         out_upc     <= '0;
         out_tid     <= '0;
         seq_err     <= 1'b0;
      end else begin
         seq_err <= beat_acc & wrap_q;
         if (flush) begin
            out_valid <= 1'b0;
            wrap_q    <= 1'b0;
            state     <= IDLE;
         end else begin
            if (start_acc) begin
               out_tid <= start_tid;
               inst_q  <= start_inst;
            end
            if (load) begin
               out_valid   <= 1'b1;
               out_inst    <= exp_inst;
               out_cwp_rs1 <= rom_w.cwp_rs1;
               out_cwp_rd  <= rom_w.cwp_rd;
               out_last    <= last_nxt;
               out_upc     <= rom_addr;
               wrap_q      <= wrap_nxt;
               state       <= RUN;
            end else if ((state == RUN) && beat_acc) begin
               // last beat retired with no follow-on start
               out_valid <= 1'b0;
               wrap_q    <= 1'b0;
               state     <= IDLE;
            end
         end
      end
   end

endmodule
